// File: rtl/logic_unit_pkg.sv
// Shared types and widths for the registered logic unit.
package logic_unit_pkg;

    localparam int OP_W      = 3;
    localparam int OPCOUNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOTA  = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSB = 3'd7
    } opcode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise function unit with zero/all-ones/parity flags.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ones_o,
    output logic             parity_o
);

    always_comb begin
        result_o = '0;
        case (opcode_e'(op_i))
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_NOTA:  result_o = ~a_i;
            OP_NAND:  result_o = ~(a_i & b_i);
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_XOR:   result_o = a_i ^ b_i;
            OP_XNOR:  result_o = ~(a_i ^ b_i);
            OP_PASSB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o   = (result_o == '0);
    assign ones_o   = &result_o;
    assign parity_o = ^result_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, accumulate mode and flags.
// Optional transaction counter enabled by defining LOGIC_UNIT_OPCOUNT_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OP_W-1:0]      op,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 res_zero,
    output logic                 res_ones,
    output logic                 res_parity,
    output logic [OPCOUNT_W-1:0] op_count
);

    out_state_e       state_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ones_q, parity_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] coreResult;
    logic             coreZero, coreOnes, coreParity;
    logic             accept, deliver;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = valid_q && out_ready;

    // A same-cycle clear makes the accumulator operand read as its reset value.
    assign bEff = acc_en ? (acc_clr ? ACC_RST : acc_q) : b;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a),
        .b_i      (bEff),
        .op_i     (op),
        .result_o (coreResult),
        .zero_o   (coreZero),
        .ones_o   (coreOnes),
        .parity_o (coreParity)
    );

    always_comb begin
        acc_d = acc_q;
        if (accept)
            acc_d = coreResult;
        else if (acc_clr)
            acc_d = ACC_RST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            parity_q <= 1'b0;
            acc_q    <= ACC_RST;
        end else begin
            acc_q <= acc_d;
            if (accept) begin
                result_q <= coreResult;
                zero_q   <= coreZero;
                ones_q   <= coreOnes;
                parity_q <= coreParity;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= ST_FULL;
                        valid_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (!accept && deliver) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign result     = result_q;
    assign res_zero   = zero_q;
    assign res_ones   = ones_q;
    assign res_parity = parity_q;

`ifdef LOGIC_UNIT_OPCOUNT_EN
    logic [OPCOUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (accept && (count_q != {OPCOUNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign op_count = count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe against a truth-table reference model.
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] ACC_RST = 8'h00;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             acc_en, acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             res_zero, res_ones, res_parity;
    logic [15:0]      op_count;

    int total = 0;
    int bad   = 0;

    logic             mValid;
    logic [WIDTH-1:0] mResult;
    logic [WIDTH-1:0] mAcc;
    int               mCount;

    logic_unit_pipe #(.WIDTH(WIDTH), .ACC_RST(ACC_RST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .acc_en     (acc_en),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .res_zero   (res_zero),
        .res_ones   (res_ones),
        .res_parity (res_parity),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal stimulus guard: an unknown opcode must never be presented as valid.
    always @(posedge clk) begin
        if (rst_n && in_valid)
            assert (!$isunknown(op)) else begin
                bad++;
                $error("[TB] FAIL op_unknown got=%b exp=known", op);
            end
    end

    // Each opcode is a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] logicRef(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [3:0] table_ [8];
        logic [3:0] t;
        logic [WIDTH-1:0] r;
        table_[0] = 4'b1000;
        table_[1] = 4'b1110;
        table_[2] = 4'b0011;
        table_[3] = 4'b0111;
        table_[4] = 4'b0001;
        table_[5] = 4'b0110;
        table_[6] = 4'b1001;
        table_[7] = 4'b1010;
        t = table_[f];
        for (int i = 0; i < WIDTH; i++)
            r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expCount();
`ifdef LOGIC_UNIT_OPCOUNT_EN
        return 16'(mCount);
`else
        return 16'd0;
`endif
    endfunction

    task automatic checkOutput();
        checkVal("out_valid", 32'(out_valid), 32'(mValid));
        if (mValid) begin
            checkVal("result", 32'(result), 32'(mResult));
            checkVal("res_zero", 32'(res_zero), 32'(mResult == 0));
            checkVal("res_ones", 32'(res_ones), 32'($countones(mResult) == WIDTH));
            checkVal("res_parity", 32'(res_parity), 32'($countones(mResult) % 2));
        end
        checkVal("op_count", 32'(op_count), 32'(expCount()));
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic [2:0] f,
                                 input logic en, input logic clr, input logic rdy,
                                 input bit doCheck);
        logic acc;
        logic [WIDTH-1:0] bEff;
        in_valid  = v;
        a         = av;
        b         = bv;
        op        = f;
        acc_en    = en;
        acc_clr   = clr;
        out_ready = rdy;
        #1;
        if (doCheck)
            checkVal("in_ready", 32'(in_ready), 32'(!mValid || rdy));
        acc = v && (!mValid || rdy);
        if (acc) begin
            bEff    = en ? (clr ? ACC_RST : mAcc) : bv;
            mResult = logicRef(f, av, bEff);
            mAcc    = mResult;
            mValid  = 1'b1;
            if (mCount < 16'hFFFF) mCount++;
        end else begin
            if (mValid && rdy) mValid = 1'b0;
            if (clr) mAcc = ACC_RST;
        end
        @(posedge clk);
        #1;
        if (doCheck) checkOutput();
    endtask

    task automatic modelReset();
        mValid  = 1'b0;
        mResult = '0;
        mAcc    = ACC_RST;
        mCount  = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] expT1 [8];
        logic [2:0] seqOps [4];
        expT1[0] = 8'h81; expT1[1] = 8'hE7; expT1[2] = 8'h3C; expT1[3] = 8'h7E;
        expT1[4] = 8'h18; expT1[5] = 8'h66; expT1[6] = 8'h99; expT1[7] = 8'hA5;
        seqOps[0] = 3'd5; seqOps[1] = 3'd6; seqOps[2] = 3'd1; seqOps[3] = 3'd2;

        rst_n = 1'b0; in_valid = 0; a = '0; b = '0; op = '0;
        acc_en = 0; acc_clr = 0; out_ready = 0;
        modelReset();
        #12;
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_result", 32'(result), 32'd0);
        checkVal("rst_res_zero", 32'(res_zero), 32'd1);
        checkVal("rst_res_ones", 32'(res_ones), 32'd0);
        checkVal("rst_res_parity", 32'(res_parity), 32'd0);
        checkVal("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] all opcodes");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'hC3, 8'hA5, 3'(i), 0, 0, 1, 1);
            checkVal("op_table", 32'(result), 32'(expT1[i]));
            if (i == 0) checkVal("parity_81", 32'(res_parity), 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

        $display("[TB] backpressure");
        applyStimulus(1, 8'hF0, 8'hFF, 3'd0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h55, 8'h0F, 3'd1, 0, 0, 0, 1);
            checkVal("bp_hold", 32'(result), 32'hF0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 8'(8'h3C + i), 8'h5A, seqOps[i], 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);

        $display("[TB] accumulate");
        applyStimulus(1, 8'h01, 8'hFF, 3'd1, 1, 1, 1, 1);
        checkVal("acc_01", 32'(result), 32'h01);
        applyStimulus(1, 8'h02, 8'hFF, 3'd1, 1, 0, 1, 1);
        checkVal("acc_03", 32'(result), 32'h03);
        applyStimulus(1, 8'h04, 8'hFF, 3'd1, 1, 0, 1, 1);
        checkVal("acc_07", 32'(result), 32'h07);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(1, 8'h00, 8'hFF, 3'd7, 1, 0, 1, 1);
        checkVal("acc_cleared", 32'(result), 32'(ACC_RST));

        $display("[TB] random");
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), 1);

        $display("[TB] async reset while full");
        applyStimulus(1, 8'hAA, 8'h0F, 3'd5, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_out_valid", 32'(out_valid), 32'd0);
        checkVal("async_res_zero", 32'(res_zero), 32'd1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 8'h00, 8'h33, 3'd7, 1, 0, 1, 1);
        checkVal("async_acc_rst", 32'(result), 32'(ACC_RST));

`ifdef LOGIC_UNIT_OPCOUNT_EN
        $display("[TB] op_count saturation");
        for (int i = 0; i < 70000; i++)
            applyStimulus(1, 8'h00, 8'(i), 3'd7, 0, 0, 1, 0);
        checkOutput();
        checkVal("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
